// File: rtl/spi_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_loader
//  Purpose  : SPI-slave (mode 0, MSB first) loader that writes 24-bit RGB
//             pixels into the LED-matrix frame buffer write port.
//             Commands: WRITE (stream from address 0), WRITE_AT (stream from
//             a big-endian 16-bit start address), FILL (whole buffer, one
//             colour).
//  Ports    : CLK_I, RST_N_I      system clock / async active-low reset
//             SCK_I, MOSI_I,      host SPI pins, asynchronous to CLK_I
//             CS_N_I
//             FB_WE_O, FB_ADDR_O, frame buffer write port (registered)
//             FB_DATA_O           pixel word: [7:0] R, [15:8] G, [23:16] B
//             FRAME_DONE_O        pulse with the write to the last address
//             BUSY_O              high during a fill
//             ERR_O               pulse on an unknown command byte
//  Revision : 1.0  initial release
// ============================================================================
module spi_frame_loader #(
   parameter int         ADDR_W       = 10,
   parameter logic [7:0] CMD_WRITE    = 8'h01,
   parameter logic [7:0] CMD_WRITE_AT = 8'h02,
   parameter logic [7:0] CMD_FILL     = 8'h03
) (
   input  logic              CLK_I,
   input  logic              RST_N_I,
   input  logic              SCK_I,
   input  logic              MOSI_I,
   input  logic              CS_N_I,
   output logic              FB_WE_O,
   output logic [ADDR_W-1:0] FB_ADDR_O,
   output logic [23:0]       FB_DATA_O,
   output logic              FRAME_DONE_O,
   output logic              BUSY_O,
   output logic              ERR_O
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CMD     = 3'd1;
   localparam logic [2:0] ST_ADDR_HI = 3'd2;
   localparam logic [2:0] ST_ADDR_LO = 3'd3;
   localparam logic [2:0] ST_DATA    = 3'd4;
   localparam logic [2:0] ST_COLOR   = 3'd5;
   localparam logic [2:0] ST_FILL    = 3'd6;
   localparam logic [2:0] ST_DROP    = 3'd7;

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   // ---------------- synchronizers and byte assembly ----------------
   logic [1:0]        sck_sync, mosi_sync, cs_sync;
   logic              sck_prev;
   logic [7:0]        shift;
   logic [2:0]        bit_cnt;
   logic [7:0]        byte_val;
   logic              byte_stb;

   logic [2:0]        state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [7:0]        addr_hi, addr_hi_nxt;
   logic [23:0]       pixel, pixel_nxt;
   logic [1:0]        byte_idx, byte_idx_nxt;
   logic              armed, armed_nxt;
   logic              we_nxt, done_nxt, busy_nxt, err_nxt;
   logic [ADDR_W-1:0] fb_addr_nxt;
   logic [23:0]       fb_data_nxt;
   logic [23:0]       pixel_full;

   wire sck_s    = sck_sync[1];
   wire mosi_s   = mosi_sync[1];
   wire cs_s     = cs_sync[1];
   wire sck_rise = sck_s & ~sck_prev;

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '0;
         sck_prev  <= 1'b0;
         shift     <= '0;
         bit_cnt   <= '0;
         byte_val  <= '0;
         byte_stb  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[0], SCK_I};
         mosi_sync <= {mosi_sync[0], MOSI_I};
         cs_sync   <= {cs_sync[0], CS_N_I};
         sck_prev  <= sck_s;
         byte_stb  <= 1'b0;
         // The host is ignored entirely while a fill runs, CS included.
         if (state != ST_FILL) begin
            if (cs_s) begin
               bit_cnt <= '0;
            end else if (sck_rise) begin
               shift   <= {shift[6:0], mosi_s};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_val <= {shift[6:0], mosi_s};
                  byte_stb <= 1'b1;
               end
            end
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         // 'armed' holds off a new command until CS has been seen high,
         // which covers both reset mid-transaction and the end of a fill.
         ST_IDLE:    if (!cs_s && armed) state_nxt = ST_CMD;
         ST_CMD:
            if (byte_stb) begin
               if (byte_val == CMD_WRITE)         state_nxt = ST_DATA;
               else if (byte_val == CMD_WRITE_AT) state_nxt = ST_ADDR_HI;
               else if (byte_val == CMD_FILL)     state_nxt = ST_COLOR;
               else                               state_nxt = ST_DROP;
            end
         ST_ADDR_HI: if (byte_stb) state_nxt = ST_ADDR_LO;
         ST_ADDR_LO: if (byte_stb) state_nxt = ST_DATA;
         ST_COLOR:   if (byte_stb && byte_idx == 2'd2) state_nxt = ST_FILL;
         ST_FILL:    if (addr == ADDR_LAST) state_nxt = ST_IDLE;
         default:    state_nxt = state;
      endcase
      if (cs_s && state != ST_FILL) state_nxt = ST_IDLE;
   end

   // ---------------- FSM: outputs and datapath next values ----------------
   always_comb begin
      addr_nxt     = addr;
      addr_hi_nxt  = addr_hi;
      pixel_nxt    = pixel;
      byte_idx_nxt = byte_idx;
      armed_nxt    = cs_s ? 1'b1 : armed;
      we_nxt       = 1'b0;
      done_nxt     = 1'b0;
      busy_nxt     = 1'b0;
      err_nxt      = 1'b0;
      fb_addr_nxt  = FB_ADDR_O;
      fb_data_nxt  = FB_DATA_O;
      pixel_full   = {byte_val, pixel[15:0]};

      case (state)
         ST_IDLE: begin
            pixel_nxt    = '0;
            byte_idx_nxt = '0;
         end
         ST_CMD:
            if (byte_stb) begin
               if (byte_val == CMD_WRITE)
                  addr_nxt = '0;
               else if (byte_val != CMD_WRITE_AT && byte_val != CMD_FILL)
                  err_nxt = 1'b1;
            end
         ST_ADDR_HI: if (byte_stb) addr_hi_nxt = byte_val;
         // Only the low ADDR_W bits of the 16-bit start address matter.
         ST_ADDR_LO: if (byte_stb) addr_nxt = ADDR_W'({addr_hi, byte_val});
         ST_DATA, ST_COLOR:
            if (byte_stb) begin
               if (byte_idx == 2'd2) begin
                  byte_idx_nxt = '0;
                  we_nxt       = 1'b1;
                  fb_data_nxt  = pixel_full;
                  if (state == ST_DATA) begin
                     fb_addr_nxt = addr;
                     done_nxt    = (addr == ADDR_LAST);
                     addr_nxt    = addr + ADDR_ONE;
                     pixel_nxt   = '0;
                  end else begin
                     // Colour complete: the first fill write (address 0)
                     // goes out now, FILL then covers 1..last.
                     fb_addr_nxt = '0;
                     busy_nxt    = 1'b1;
                     addr_nxt    = ADDR_ONE;
                     pixel_nxt   = pixel_full;
                  end
               end else begin
                  byte_idx_nxt = byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0:    pixel_nxt[7:0]  = byte_val;
                     default: pixel_nxt[15:8] = byte_val;
                  endcase
               end
            end
         ST_FILL: begin
            we_nxt      = 1'b1;
            busy_nxt    = 1'b1;
            fb_addr_nxt = addr;
            fb_data_nxt = pixel;
            done_nxt    = (addr == ADDR_LAST);
            addr_nxt    = addr + ADDR_ONE;
            armed_nxt   = 1'b0;
         end
         default: ;
      endcase

      // CS high abandons the transaction, including any partial pixel.
      if (cs_s && state != ST_FILL) begin
         pixel_nxt    = '0;
         byte_idx_nxt = '0;
         we_nxt       = 1'b0;
         done_nxt     = 1'b0;
         busy_nxt     = 1'b0;
         err_nxt      = 1'b0;
         fb_addr_nxt  = FB_ADDR_O;
         fb_data_nxt  = FB_DATA_O;
      end
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         addr         <= '0;
         addr_hi      <= '0;
         pixel        <= '0;
         byte_idx     <= '0;
         armed        <= 1'b0;
         FB_WE_O      <= 1'b0;
         FB_ADDR_O    <= '0;
         FB_DATA_O    <= '0;
         FRAME_DONE_O <= 1'b0;
         BUSY_O       <= 1'b0;
         ERR_O        <= 1'b0;
      end else begin
         addr         <= addr_nxt;
         addr_hi      <= addr_hi_nxt;
         pixel        <= pixel_nxt;
         byte_idx     <= byte_idx_nxt;
         armed        <= armed_nxt;
         FB_WE_O      <= we_nxt;
         FB_ADDR_O    <= fb_addr_nxt;
         FB_DATA_O    <= fb_data_nxt;
         FRAME_DONE_O <= done_nxt;
         BUSY_O       <= busy_nxt;
         ERR_O        <= err_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spi_frame_loader
//  Purpose  : directed self-checking bench for spi_frame_loader, built with a
//             64-entry buffer so a full-frame stream stays short.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_frame_loader;

   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sck = 1'b0;
   logic          mosi = 1'b0;
   logic          cs_n = 1'b1;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [23:0]   fb_data;
   logic          frame_done;
   logic          busy;
   logic          err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rise_cyc = 0;

   // monitor state
   logic [AW-1:0] wr_addr_q[$];
   logic [23:0]   wr_data_q[$];
   int            wr_cyc_q[$];
   int            done_cnt, done_addr, done_no_we, err_cnt, busy_cnt;

   spi_frame_loader #(.ADDR_W(AW)) dut (
      .CLK_I       (clk),
      .RST_N_I     (rst_n),
      .SCK_I       (sck),
      .MOSI_I      (mosi),
      .CS_N_I      (cs_n),
      .FB_WE_O     (fb_we),
      .FB_ADDR_O   (fb_addr),
      .FB_DATA_O   (fb_data),
      .FRAME_DONE_O(frame_done),
      .BUSY_O      (busy),
      .ERR_O       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (fb_we) begin
         wr_addr_q.push_back(fb_addr);
         wr_data_q.push_back(fb_data);
         wr_cyc_q.push_back(cyc);
      end
      if (frame_done) begin
         done_cnt++;
         done_addr = int'(fb_addr);
         if (!fb_we) done_no_we++;
      end
      if (err)  err_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      done_cnt = 0; done_addr = -1; done_no_we = 0; err_cnt = 0; busy_cnt = 0;
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         @(negedge clk);
         mosi = b[i];
         clk_wait(4);
         sck = 1'b1;
         rise_cyc = cyc;
         clk_wait(4);
         sck = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 8);
   endtask

   task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] bl);
      send_byte(r); send_byte(g); send_byte(bl);
   endtask

   task automatic cs_assert();
      @(negedge clk); cs_n = 1'b0;
      clk_wait(4);
   endtask

   task automatic cs_release();
      clk_wait(4);
      @(negedge clk); cs_n = 1'b1;
      clk_wait(8);
   endtask

   task automatic test_reset();
      clk_wait(5);
      @(negedge clk); rst_n = 1'b1;
      clk_wait(3);
      checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", fb_we); end
      checks++; if (fb_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", fb_addr); end
      checks++; if (fb_data !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=000000", fb_data); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
   endtask

   task automatic test_frame_write();
      logic [AW-1:0] ea;
      int lat_ref;
      lat_ref = 0;
      clear_mon();
      cs_assert();
      send_byte(8'h01);
      for (int p = 0; p < DEPTH; p++) begin
         send_pixel(8'h11, 8'h22, 8'h33);
         if (p == 0) lat_ref = rise_cyc;
      end
      cs_release();
      checks++; if (wr_addr_q.size() != DEPTH) begin failures++; $display("FAIL frame_count got=%0d exp=%0d", wr_addr_q.size(), DEPTH); end
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         ea = AW'(i);
         checks++; if (wr_addr_q[i] !== ea) begin failures++; $display("FAIL frame_addr[%0d] got=%0d exp=%0d", i, wr_addr_q[i], ea); end
         checks++; if (wr_data_q[i] !== 24'h332211) begin failures++; $display("FAIL frame_data[%0d] got=%h exp=332211", i, wr_data_q[i]); end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL frame_done_count got=%0d exp=1", done_cnt); end
      checks++; if (done_addr != DEPTH - 1) begin failures++; $display("FAIL frame_done_addr got=%0d exp=%0d", done_addr, DEPTH - 1); end
      checks++; if (done_no_we != 0) begin failures++; $display("FAIL frame_done_without_we got=%0d exp=0", done_no_we); end
      if (wr_cyc_q.size() > 0) begin
         checks++; if (wr_cyc_q[0] - lat_ref != 4) begin failures++; $display("FAIL write_latency got=%0d exp=4", wr_cyc_q[0] - lat_ref); end
      end
   endtask

   task automatic test_write_at_wrap();
      clear_mon();
      cs_assert();
      send_byte(8'h02); send_byte(8'h03); send_byte(8'hFF);
      send_pixel(8'h01, 8'h02, 8'h03);
      send_pixel(8'h04, 8'h05, 8'h06);
      cs_release();
      checks++; if (wr_addr_q.size() != 2) begin failures++; $display("FAIL wat_count got=%0d exp=2", wr_addr_q.size()); end
      if (wr_addr_q.size() >= 2) begin
         checks++; if (wr_addr_q[0] !== 6'd63) begin failures++; $display("FAIL wat_addr0 got=%0d exp=63", wr_addr_q[0]); end
         checks++; if (wr_data_q[0] !== 24'h030201) begin failures++; $display("FAIL wat_data0 got=%h exp=030201", wr_data_q[0]); end
         checks++; if (wr_addr_q[1] !== 6'd0) begin failures++; $display("FAIL wat_addr1 got=%0d exp=0", wr_addr_q[1]); end
         checks++; if (wr_data_q[1] !== 24'h060504) begin failures++; $display("FAIL wat_data1 got=%h exp=060504", wr_data_q[1]); end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL wat_done_count got=%0d exp=1", done_cnt); end
      checks++; if (done_addr != 63) begin failures++; $display("FAIL wat_done_addr got=%0d exp=63", done_addr); end
   endtask

   task automatic test_partial_and_badcmd();
      clear_mon();
      cs_assert();
      send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
      cs_release();
      checks++; if (wr_addr_q.size() != 0) begin failures++; $display("FAIL partial_nowrite got=%0d exp=0", wr_addr_q.size()); end
      cs_assert();
      send_byte(8'h01);
      send_pixel(8'h10, 8'h20, 8'h30);
      cs_release();
      checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL after_partial_count got=%0d exp=1", wr_addr_q.size()); end
      if (wr_addr_q.size() >= 1) begin
         checks++; if (wr_addr_q[0] !== 6'd0) begin failures++; $display("FAIL after_partial_addr got=%0d exp=0", wr_addr_q[0]); end
         checks++; if (wr_data_q[0] !== 24'h302010) begin failures++; $display("FAIL after_partial_data got=%h exp=302010", wr_data_q[0]); end
      end
      clear_mon();
      cs_assert();
      send_byte(8'h7E); send_byte(8'h01);
      send_pixel(8'h11, 8'h22, 8'h33);
      cs_release();
      checks++; if (err_cnt != 1) begin failures++; $display("FAIL badcmd_err got=%0d exp=1", err_cnt); end
      checks++; if (wr_addr_q.size() != 0) begin failures++; $display("FAIL badcmd_nowrite got=%0d exp=0", wr_addr_q.size()); end
      cs_assert();
      send_byte(8'h01);
      send_pixel(8'h44, 8'h55, 8'h66);
      cs_release();
      checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL recover_count got=%0d exp=1", wr_addr_q.size()); end
      if (wr_data_q.size() >= 1) begin
         checks++; if (wr_data_q[0] !== 24'h665544) begin failures++; $display("FAIL recover_data got=%h exp=665544", wr_data_q[0]); end
      end
      checks++; if (err_cnt != 1) begin failures++; $display("FAIL recover_err got=%0d exp=1", err_cnt); end
   endtask

   task automatic test_fill();
      logic [AW-1:0] ea;
      clear_mon();
      cs_assert();
      send_byte(8'h03); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
      // host keeps clocking during and after the fill
      send_byte(8'h01); send_byte(8'h01);
      cs_release();
      checks++; if (wr_addr_q.size() != DEPTH) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", wr_addr_q.size(), DEPTH); end
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         ea = AW'(i);
         checks++; if (wr_addr_q[i] !== ea) begin failures++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, wr_addr_q[i], ea); end
         checks++; if (wr_data_q[i] !== 24'h00FF00) begin failures++; $display("FAIL fill_data[%0d] got=%h exp=00ff00", i, wr_data_q[i]); end
      end
      if (wr_cyc_q.size() == DEPTH) begin
         checks++; if (wr_cyc_q[DEPTH-1] - wr_cyc_q[0] != DEPTH - 1) begin failures++; $display("FAIL fill_span got=%0d exp=%0d", wr_cyc_q[DEPTH-1] - wr_cyc_q[0], DEPTH - 1); end
      end
      checks++; if (busy_cnt != DEPTH) begin failures++; $display("FAIL fill_busy_cycles got=%0d exp=%0d", busy_cnt, DEPTH); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL fill_done_count got=%0d exp=1", done_cnt); end
      checks++; if (done_addr != DEPTH - 1) begin failures++; $display("FAIL fill_done_addr got=%0d exp=%0d", done_addr, DEPTH - 1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fill_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_reset_midstream();
      cs_assert();
      send_byte(8'h01); send_byte(8'h11); send_bits(8'h22, 4);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL midrst_we got=%b exp=0", fb_we); end
      checks++; if (fb_addr !== '0) begin failures++; $display("FAIL midrst_addr got=%0d exp=0", fb_addr); end
      checks++; if (fb_data !== 24'h0) begin failures++; $display("FAIL midrst_data got=%h exp=000000", fb_data); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", frame_done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", err); end
      clk_wait(3);
      @(negedge clk); rst_n = 1'b1;
      clear_mon();
      cs_release();
      cs_assert();
      send_byte(8'h01);
      send_pixel(8'hA1, 8'hB2, 8'hC3);
      cs_release();
      checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL postrst_count got=%0d exp=1", wr_addr_q.size()); end
      if (wr_addr_q.size() >= 1) begin
         checks++; if (wr_addr_q[0] !== 6'd0) begin failures++; $display("FAIL postrst_addr got=%0d exp=0", wr_addr_q[0]); end
         checks++; if (wr_data_q[0] !== 24'hC3B2A1) begin failures++; $display("FAIL postrst_data got=%h exp=c3b2a1", wr_data_q[0]); end
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_frame_write();
      test_write_at_wrap();
      test_partial_and_badcmd();
      test_fill();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
